riscv_regfile_debug_access: RTL and testbench

RISCV_REGFILE_DEBUG_ACCESS -- requirements
Module: riscv_regfile_debug_access

---
 rtl/riscv_regfile_debug_access_if.sv | 23 ++
 rtl/riscv_regfile_debug_access.sv | 130 +++++++++++++
 tb/tb_riscv_regfile_debug_access.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_regfile_debug_access_if.sv
// Debug command/response handshake between a debug module (master) and the
// GPR access block (slave).
interface riscv_regfile_debug_access_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_regno;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_regno, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_regno, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/riscv_regfile_debug_access.sv
// Debug-side GPR read/write access while the core is halted. One command
// in flight; reads take two cycles through the registered-address file.
module riscv_regfile_debug_access (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               core_halted,
  riscv_regfile_debug_access_if.slave        dbg,
  output logic [4:0]                         rf_rs_addr,
  input  logic [31:0]                        rf_rs_data,
  output logic [4:0]                         rf_rd_addr,
  output logic [31:0]                        rf_rd_data,
  output logic                               rf_rd_write
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    RESP
  } state_e;

  state_e      state_q;
  logic [4:0]  regno_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [4:0]  rf_rs_addr_q;
  logic [4:0]  rf_rd_addr_q;
  logic [31:0] rf_rd_data_q;
  logic        rd_write_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      regno_q      <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rf_rs_addr_q <= '0;
      rf_rd_addr_q <= '0;
      rf_rd_data_q <= '0;
      rd_write_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (dbg.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            regno_q     <= dbg.cmd_regno;
            if (!core_halted) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (dbg.cmd_write) begin
              state_q      <= WR;
              rf_rd_addr_q <= dbg.cmd_regno;
              rf_rd_data_q <= dbg.cmd_wdata;
              rd_write_q   <= (dbg.cmd_regno != 5'd0);
            end else begin
              state_q      <= RD_ADDR;
              rf_rs_addr_q <= dbg.cmd_regno;
            end
          end
        end
        RD_ADDR: begin
          if (!core_halted) begin
            state_q      <= RESP;
            rf_rs_addr_q <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_rdata_q  <= '0;
          end else begin
            state_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          state_q      <= RESP;
          rf_rs_addr_q <= '0;
          rsp_valid_q  <= 1'b1;
          rsp_err_q    <= !core_halted;
          rsp_rdata_q  <= (core_halted && regno_q != 5'd0) ? rf_rs_data : '0;
        end
        WR: begin
          state_q      <= RESP;
          rf_rd_addr_q <= '0;
          rf_rd_data_q <= '0;
          rd_write_q   <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_err_q    <= !core_halted;
          rsp_rdata_q  <= '0;
        end
        RESP: begin
          if (dbg.rsp_ready) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          cmd_ready_q  <= 1'b0;
          rsp_valid_q  <= 1'b0;
          rsp_err_q    <= 1'b0;
          rsp_rdata_q  <= '0;
          rf_rs_addr_q <= '0;
          rf_rd_addr_q <= '0;
          rf_rd_data_q <= '0;
          rd_write_q   <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe is gated by core_halted so a mid-WR halt drop suppresses it in the same cycle.
  assign rf_rd_write   = rd_write_q & core_halted;
  assign rf_rs_addr    = rf_rs_addr_q;
  assign rf_rd_addr    = rf_rd_addr_q;
  assign rf_rd_data    = rf_rd_data_q;
  assign dbg.cmd_ready = cmd_ready_q;
  assign dbg.rsp_valid = rsp_valid_q;
  assign dbg.rsp_rdata = rsp_rdata_q;
  assign dbg.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_riscv_regfile_debug_access.sv
// Randomized bench for riscv_regfile_debug_access with a register-file model
// and a command-level reference model (latency, response, write effects).
module tb_riscv_regfile_debug_access;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_halted = 1'b0;
  logic [4:0]  rf_rs_addr;
  logic [31:0] rf_rs_data;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_rd_write;

  riscv_regfile_debug_access_if dbg ();

  riscv_regfile_debug_access dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .core_halted (core_halted),
    .dbg         (dbg),
    .rf_rs_addr  (rf_rs_addr),
    .rf_rs_data  (rf_rs_data),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .rf_rd_write (rf_rd_write)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (32'h9E37_79B9 * (i + 1)) ^ 32'h5A5A_0000;
  endfunction

  // Register file model: registered read address, write on strobe; not reset.
  logic [31:0] rf_mem [32];
  bit          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else if (rf_rd_write) begin
      rf_mem[rf_rd_addr] <= rf_rd_data;
    end
    rf_rs_data <= rf_mem[rf_rs_addr];
  end

  // Architectural view of the GPRs as seen through debug accesses.
  logic [31:0] ref_gpr [32];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // scen: 0 = halted throughout, 1 = not halted at accept, 2 = halt drops in first busy cycle
  typedef struct {
    bit          wr;
    logic [4:0]  rn;
    logic [31:0] wd;
    int          scen;
    int          stall;
    bit          b2b;
  } cmd_t;

  cmd_t cq[$];

  task automatic drive_fields(input cmd_t c);
    dbg.cmd_valid = 1'b1;
    dbg.cmd_write = c.wr;
    dbg.cmd_regno = c.rn;
    dbg.cmd_wdata = c.wd;
  endtask

  // Entered and left at #1 after a falling edge.
  task automatic run_cmd(input cmd_t c, input bit has_next, input cmd_t nx);
    int          w;
    int          lat;
    int          pulses;
    int          exp_lat;
    int          exp_pulses;
    logic        exp_err;
    logic [31:0] exp_rd;
    drive_fields(c);
    core_halted = (c.scen != 1);
    w = 0;
    while (!dbg.cmd_ready && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    if (!dbg.cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      dbg.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_err    = (c.scen != 0);
    exp_rd     = (!exp_err && !c.wr && c.rn != 5'd0) ? ref_gpr[c.rn] : 32'd0;
    exp_lat    = (c.scen == 1) ? 1 : (c.scen == 2) ? 2 : (c.wr ? 2 : 3);
    exp_pulses = (c.scen == 0 && c.wr && c.rn != 5'd0) ? 1 : 0;
    if (exp_pulses == 1) ref_gpr[c.rn] = c.wd;
    lat = 0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (has_next) drive_fields(nx);
        else dbg.cmd_valid = 1'b0;
        if (c.scen == 2) core_halted = 1'b0;
      end
      #1;
      if (dbg.rsp_valid) begin
        lat = k;
        break;
      end
      if (rf_rd_write) begin
        pulses++;
        chk("wr_addr", 32'(rf_rd_addr), 32'(c.rn));
        chk("wr_data", rf_rd_data, c.wd);
        chk("wr_cycle", 32'(k), 32'd1);
      end
      if (!c.wr && c.scen == 0) chk("rs_addr", 32'(rf_rs_addr), 32'(c.rn));
      chk("busy_ready", 32'(dbg.cmd_ready), 32'd0);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("wr_pulses", 32'(pulses), 32'(exp_pulses));
    if (lat == 0) return;
    for (int s = 0; s <= c.stall; s++) begin
      dbg.rsp_ready = (s == c.stall);
      chk("rsp_valid", 32'(dbg.rsp_valid), 32'd1);
      chk("rsp_rdata", dbg.rsp_rdata, exp_rd);
      chk("rsp_err", 32'(dbg.rsp_err), 32'(exp_err));
      chk("resp_ready", 32'(dbg.cmd_ready), 32'd0);
      chk("resp_wr", 32'(rf_rd_write), 32'd0);
      if (s < c.stall) begin
        @(negedge clk); #1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    dbg.rsp_ready = 1'b0;
    #1;
    chk("post_rsp_valid", 32'(dbg.rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(dbg.cmd_ready), 32'd1);
    chk("idle_rf_zero", {rf_rd_data[26:0], rf_rs_addr}, 32'd0);
    chk("idle_rd_addr", 32'(rf_rd_addr), 32'd0);
  endtask

  task automatic reset_mid_read();
    cmd_t c;
    c = '{wr: 1'b0, rn: 5'd5, wd: 32'd0, scen: 0, stall: 0, b2b: 1'b0};
    drive_fields(c);
    core_halted = 1'b1;
    for (int w = 0; w < 20 && !dbg.cmd_ready; w++) begin
      @(negedge clk); #1;
    end
    chk("rst_accept_ready", 32'(dbg.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    dbg.cmd_valid = 1'b0;
    @(negedge clk); #1;
    chk("rst_rs_addr_before", 32'(rf_rs_addr), 32'd5);
    reset_n = 1'b0;
    #1;
    chk("rst_rs_addr", 32'(rf_rs_addr), 32'd0);
    chk("rst_rsp_valid", 32'(dbg.rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(dbg.cmd_ready), 32'd0);
    chk("rst_rsp_rdata", dbg.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(dbg.rsp_err), 32'd0);
    chk("rst_wr", 32'(rf_rd_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_hold_valid", 32'(dbg.rsp_valid), 32'd0);
      chk("rst_hold_ready", 32'(dbg.cmd_ready), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rel_rsp_valid", 32'(dbg.rsp_valid), 32'd0);
      chk("rel_cmd_ready", 32'(dbg.cmd_ready), 32'd1);
    end
  endtask

  task automatic run_queue();
    cmd_t nx;
    bit   hn;
    for (int i = 0; i < cq.size(); i++) begin
      hn = cq[i].b2b && (i + 1 < cq.size());
      nx = hn ? cq[i + 1] : cq[i];
      run_cmd(cq[i], hn, nx);
      if (!hn) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk); #1;
        end
      end
    end
    cq.delete();
  endtask

  initial begin
    cmd_t c;
    dbg.cmd_valid = 1'b0;
    dbg.cmd_write = 1'b0;
    dbg.cmd_regno = '0;
    dbg.cmd_wdata = '0;
    dbg.rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) ref_gpr[i] = init_val(i);

    @(negedge clk); #1;
    chk("reset_cmd_ready", 32'(dbg.cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(dbg.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", dbg.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(dbg.rsp_err), 32'd0);
    chk("reset_rf_wr", 32'(rf_rd_write), 32'd0);
    chk("reset_rf_addr", {22'd0, rf_rs_addr, rf_rd_addr}, 32'd0);
    chk("reset_rf_data", rf_rd_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("release_cmd_ready", 32'(dbg.cmd_ready), 32'd1);

    cq.push_back('{wr: 1'b1, rn: 5'd5, wd: 32'hDEAD_BEEF, scen: 0, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b0, rn: 5'd5, wd: 32'd0,         scen: 0, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b0, rn: 5'd0, wd: 32'd0,         scen: 0, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b1, rn: 5'd0, wd: 32'h0000_1234, scen: 0, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b0, rn: 5'd0, wd: 32'd0,         scen: 0, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b0, rn: 5'd5, wd: 32'd0,         scen: 1, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b1, rn: 5'd6, wd: 32'h1111_2222, scen: 1, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b1, rn: 5'd7, wd: 32'hCAFE_F00D, scen: 2, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b0, rn: 5'd7, wd: 32'd0,         scen: 0, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b0, rn: 5'd5, wd: 32'd0,         scen: 2, stall: 0, b2b: 1'b0});
    cq.push_back('{wr: 1'b0, rn: 5'd5, wd: 32'd0,         scen: 0, stall: 5, b2b: 1'b1});
    cq.push_back('{wr: 1'b1, rn: 5'd9, wd: 32'h0BAD_C0DE, scen: 0, stall: 2, b2b: 1'b1});
    cq.push_back('{wr: 1'b0, rn: 5'd9, wd: 32'd0,         scen: 0, stall: 0, b2b: 1'b0});
    run_queue();

    reset_mid_read();
    cq.push_back('{wr: 1'b0, rn: 5'd5, wd: 32'd0, scen: 0, stall: 0, b2b: 1'b0});
    run_queue();

    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 99);
      c.wr    = $urandom_range(0, 1) == 1;
      c.rn    = ($urandom_range(0, 3) == 0) ? 5'(0) : 5'($urandom_range(0, 7));
      c.wd    = $urandom;
      c.scen  = (r < 70) ? 0 : (r < 85) ? 1 : 2;
      c.stall = $urandom_range(0, 3);
      c.b2b   = $urandom_range(0, 1) == 1;
      cq.push_back(c);
    end
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
